// File: rtl/wts_tone_generator_if.sv
// Channel-select and sample-address bus between the tone generator, its
// channel register selector and the downstream wave RAM / mixer stage.
interface wts_tone_generator_if #(
  parameter int freq_bits = 12,
  parameter int addr_bits = 5
);
  logic                 enable;
  logic [5:0]           key_on;
  logic [2:0]           active;
  logic [freq_bits-1:0] reg_freq;
  logic                 wave_valid;
  logic [2:0]           wave_channel;
  logic [addr_bits-1:0] wave_address;

  // master: the tone generator itself
  modport master (
    input  enable, key_on, reg_freq,
    output active, wave_valid, wave_channel, wave_address
  );

  modport slave (
    output enable, key_on, reg_freq,
    input  active, wave_valid, wave_channel, wave_address
  );
endinterface

// File: rtl/wts_tone_generator.sv
// Time-division phase engine for six wave-table channels: one slot per enabled
// cycle. Optional per-channel phase reset port when WTS_PHASE_RESET_EN is defined.
module wts_tone_generator #(
  parameter int freq_bits      = 12,
  parameter int addr_bits      = 5,
  parameter int halt_threshold = 9
) (
  input  logic clk,
  input  logic reset,
  wts_tone_generator_if.master tg
`ifdef WTS_PHASE_RESET_EN
  ,
  input  logic [5:0] phase_reset
`endif
);

  localparam int n_chan = 6;

  logic [2:0]           active_q, active_d;
  logic                 wave_valid_q, wave_valid_d;
  logic [2:0]           wave_channel_q, wave_channel_d;
  logic [addr_bits-1:0] wave_address_q, wave_address_d;
  logic [freq_bits-1:0] cnt_q [n_chan];
  logic [freq_bits-1:0] cnt_d [n_chan];
  logic [addr_bits-1:0] addr_q [n_chan];
  logic [addr_bits-1:0] addr_d [n_chan];

  logic [2:0] slot;
  logic       run;

  assign slot = active_q;
  assign run  = tg.enable && tg.key_on[slot] &&
                (tg.reg_freq >= freq_bits'(halt_threshold));

  always_comb begin
    active_d       = active_q;
    wave_valid_d   = 1'b0;
    wave_channel_d = wave_channel_q;
    wave_address_d = wave_address_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;

    // Reload happens on the visit that finds the counter already at zero,
    // so a channel advances once per reg_freq+1 visits.
    if (run) begin
      if (cnt_q[slot] == '0) begin
        cnt_d[slot]  = tg.reg_freq;
        addr_d[slot] = addr_q[slot] + addr_bits'(1);
      end else begin
        cnt_d[slot] = cnt_q[slot] - freq_bits'(1);
      end
    end

`ifdef WTS_PHASE_RESET_EN
    for (int n = 0; n < n_chan; n++) begin
      if (phase_reset[n]) begin
        cnt_d[n]  = '0;
        addr_d[n] = '0;
      end
    end
`endif

    if (tg.enable) begin
      wave_valid_d   = 1'b1;
      wave_channel_d = slot;
      wave_address_d = addr_d[slot];
      active_d       = (slot == 3'd5) ? 3'd0 : slot + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q       <= '0;
      wave_valid_q   <= 1'b0;
      wave_channel_q <= '0;
      wave_address_q <= '0;
      for (int n = 0; n < n_chan; n++) begin
        cnt_q[n]  <= '0;
        addr_q[n] <= '0;
      end
    end else begin
      active_q       <= active_d;
      wave_valid_q   <= wave_valid_d;
      wave_channel_q <= wave_channel_d;
      wave_address_q <= wave_address_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
    end
  end

  assign tg.active       = active_q;
  assign tg.wave_valid   = wave_valid_q;
  assign tg.wave_channel = wave_channel_q;
  assign tg.wave_address = wave_address_q;

endmodule

// File: doc/wts_tone_generator.md
Name: wts_tone_generator

Overview:
- Time-division phase engine for the six wave-table channels.
- Each enabled cycle it drives the channel index `active` (0..5) into the six-way channel register selector.
- It takes back that channel's frequency value, then updates the channel's period down-counter and wave-table read address.
- It presents the resulting sample address, registered, to the downstream wave RAM / mixer stage.

Parameters:
- freq_bits, 12, width of the frequency (period) value per channel.
- addr_bits, 5, width of the wave-table sample address (32 samples per channel).
- halt_threshold, 9, frequency values below this stop the channel (counter and address frozen).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- enable  input  1  processing strobe; one channel slot is processed per cycle with enable=1.
- key_on  input  6  per-channel run enable, bit n = channel n.
- active  output  3  current channel slot index to the selector, 0..5.
- reg_freq  input  freq_bits  selected channel frequency, returned combinationally by the selector for the current `active`.
- wave_valid  output  1  one-cycle strobe: wave_channel and wave_address are valid.
- wave_channel  output  3  channel the address belongs to.
- wave_address  output  addr_bits  sample address for that channel.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - active=0, wave_valid=0, wave_channel=0, wave_address=0.
  - All six internal counters (freq_bits each) = 0.
  - All six internal addresses (addr_bits each) = 0.
- Reset wins over enable in the same cycle. Reset mid-sweep restarts at slot 0 with cleared state.
- enable=0: active, counters and addresses hold; wave_valid=0 the following cycle; wave_channel/wave_address hold their last values.
- enable=1, slot s=active, at the clock edge:
  - If key_on[s]=0 or reg_freq<halt_threshold: counter[s] and addr[s] hold.
  - Else if counter[s]==0: counter[s]<=reg_freq and addr[s]<=addr[s]+1, wrapping modulo 2^addr_bits (31->0).
  - Else: counter[s]<=counter[s]-1.
  - Outputs: wave_valid<=1, wave_channel<=s, wave_address<=the post-update addr[s].
  - Slot advance: active<=s+1, with 5->0 wrap.
- Latency: output for slot s is registered, valid exactly one cycle after the enable cycle that processed s.
- Advance period: the address advances once per reg_freq+1 visits to the channel, i.e. every 6*(reg_freq+1) enable cycles.
- Frequency changes between visits take effect only at the next reload; a running count is never truncated.
- reg_freq is sampled only in the cycle its slot is processed.
- key_on falling: state freezes at current values. key_on rising: resumes from the frozen counter/address.
- First visit after reset with a running channel: counter is 0, so it reloads immediately and the address becomes 1.
- active never takes values 6 or 7.

Optional Feature:
- Macro: WTS_PHASE_RESET_EN.
- Defined: adds input port phase_reset, 6 bits.
  - On any cycle, a set bit n forces counter[n]<=0 and addr[n]<=0.
  - This overrides the normal update, including when n is the slot being processed that cycle.
  - If n is the slot being processed, wave_address reports 0.
  - key_on and halt rules do not block phase_reset.
- Not defined: the port is absent; the phase of a channel changes only through normal counting and reset.

Test Plan:
- Slot sequence: reset, then enable=1 continuously for 14 cycles -> active sequence 0,1,2,3,4,5,0,1,...; wave_valid=1 from the 2nd cycle; wave_channel lags active by exactly one cycle.
- Period check: key_on=6'b000001, reg_freq=9 for slot 0, enable continuous -> channel 0 address reads 1 at its first visit, 2 at its 11th visit (60 cycles later), 3 at its 21st visit.
- Halt threshold: reg_freq=8 on channel 2 with key_on set -> channel 2 address stays 0 for 100 visits; change to 9 -> address becomes 1 on the next visit.
- Wrap and enable gaps: reg_freq=9, run channel 0 to address 31 with enable toggling 1/0 -> next advance gives 0; wave_valid=0 and active frozen in every enable=0 cycle.
- Reset mid-operation: reset asserted together with enable=1 while active=4 -> next cycle active=0, wave_valid=0, and all addresses 0 on subsequent visits.
- With WTS_PHASE_RESET_EN: channel 3 at address 17; pulse phase_reset[3] in the cycle slot 3 is processed -> wave_address=0, and the next advance gives address 1.
